// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-instruction Harvard core: opcodes, fetch FSM
// states and the default reset vector.
package cpu_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_HALT  = 6'h3F;
  localparam logic [5:0]  FUNC_JR  = 6'h08;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Instruction addresses must be word aligned; low two bits select a byte.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// PC / IR owner and FETCH-EXEC phase sequencer with one branch-delay slot;
// feeds opcode/func to the control decoder and consumes its branch/halt.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_read,
  input  logic [31:0]       instr_rdata,
  output logic              state,
  output logic [5:0]        instruction_opcode,
  output logic [5:0]        func_code,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic              active,
  output logic              addr_error
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  fetch_state_t      fsm_r, fsm_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [31:0]       ir_r, ir_s;
  logic              pending_r, pending_s;
  logic [ADDR_W-1:0] pending_target_r, pending_target_s;
  logic              active_r, active_s;
  logic              addr_error_r, addr_error_s;
  logic              state_r;
  logic              instr_read_r;

  // Next-state logic; branch/halt/target are only looked at in EXEC so they
  // cannot disturb state (or spread X) in FETCH or HALTED.
  always_comb begin
    fsm_s            = fsm_r;
    pc_s             = pc_r;
    ir_s             = ir_r;
    pending_s        = pending_r;
    pending_target_s = pending_target_r;
    active_s         = active_r;
    addr_error_s     = addr_error_r;
    case (fsm_r)
      FETCH: begin
        ir_s  = instr_rdata;
        fsm_s = EXEC;
      end
      EXEC: begin
        if (halt) begin
          fsm_s    = HALTED;
          active_s = 1'b0;
        end else if (branch && !is_word_aligned(branch_target[1:0])) begin
          fsm_s        = HALTED;
          active_s     = 1'b0;
          addr_error_s = 1'b1;
        end else begin
          // A branch taken by the previous instruction lands now; this
          // instruction was its delay slot.
          if (pending_r) begin
            pc_s = pending_target_r;
          end else begin
            pc_s = pc_r + PC_STEP;
          end
          pending_s = branch;
          if (branch) begin
            pending_target_s = branch_target;
          end else begin
            pending_target_s = pending_target_r;
          end
          fsm_s = FETCH;
        end
      end
      HALTED: begin
        fsm_s    = HALTED;
        active_s = 1'b0;
      end
      default: begin
        fsm_s    = HALTED;
        active_s = 1'b0;
      end
    endcase
  end

  // State registers; state/instr_read are registered from the next FSM value.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r            <= FETCH;
      pc_r             <= RESET_VECTOR;
      ir_r             <= 32'h0000_0000;
      pending_r        <= 1'b0;
      pending_target_r <= '0;
      active_r         <= 1'b1;
      addr_error_r     <= 1'b0;
      state_r          <= 1'b0;
      instr_read_r     <= 1'b1;
    end else begin
      fsm_r            <= fsm_s;
      pc_r             <= pc_s;
      ir_r             <= ir_s;
      pending_r        <= pending_s;
      pending_target_r <= pending_target_s;
      active_r         <= active_s;
      addr_error_r     <= addr_error_s;
      state_r          <= (fsm_s == EXEC);
      instr_read_r     <= (fsm_s == FETCH);
    end
  end

  assign instr_addr         = pc_r;
  assign pc                 = pc_r;
  assign ir                 = ir_r;
  assign instruction_opcode = ir_r[31:26];
  assign func_code          = ir_r[5:0];
  assign state              = state_r;
  assign instr_read         = instr_read_r;
  assign active             = active_r;
  assign addr_error         = addr_error_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: instruction-indexed reference model
// compared every cycle, directed scenarios with literal expectations, random run.
module tb_fetch_sequencer;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_addr;
  logic        instr_read;
  logic [31:0] instr_rdata;
  logic        state;
  logic [5:0]  instruction_opcode;
  logic [5:0]  func_code;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        branch = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        halt = 1'b0;
  logic        active;
  logic        addr_error;

  int checks = 0;
  int failures = 0;

  fetch_sequencer #(.ADDR_W(32), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr_read(instr_read), .instr_rdata(instr_rdata),
    .state(state), .instruction_opcode(instruction_opcode), .func_code(func_code),
    .ir(ir), .pc(pc),
    .branch(branch), .branch_target(branch_target), .halt(halt),
    .active(active), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  // Instruction ROM contents: a fixed hash of the address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[7:2], a[27:8] ^ 20'hA5C3E, a[7:2]};
  endfunction

  always_comb instr_rdata = rom(instr_addr);

  // Reference model: program-order view. Instruction k+1 sits at pc(k)+4 unless
  // a branch taken by instruction k-1 named its address.
  logic        model_valid = 1'b0;
  logic [31:0] m_pc, m_ir;
  logic        m_exec, m_halted, m_active, m_err;
  int          m_idx;
  int          m_halt_cycles;
  logic [31:0] redir [int];

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1'b1;
      m_pc = RV; m_ir = 32'h0; m_exec = 1'b0; m_halted = 1'b0;
      m_active = 1'b1; m_err = 1'b0; m_idx = 0; m_halt_cycles = 0;
      redir.delete();
    end else if (model_valid) begin
      if (m_halted) begin
        m_halt_cycles = m_halt_cycles + 1;
      end else if (!m_exec) begin
        m_ir = rom(m_pc);
        m_exec = 1'b1;
      end else begin
        m_exec = 1'b0;
        if (halt) begin
          m_halted = 1'b1; m_active = 1'b0;
        end else if (branch && (branch_target % 4 != 0)) begin
          m_halted = 1'b1; m_active = 1'b0; m_err = 1'b1;
        end else begin
          if (branch) redir[m_idx + 2] = branch_target;
          m_idx = m_idx + 1;
          if (redir.exists(m_idx)) begin
            m_pc = redir[m_idx];
            redir.delete(m_idx);
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      checks = checks + 1;
      if (instr_addr !== m_pc || pc !== m_pc || ir !== m_ir || state !== m_exec ||
          instr_read !== (!m_exec && !m_halted) || active !== m_active ||
          addr_error !== m_err || instruction_opcode !== m_ir[31:26] ||
          func_code !== m_ir[5:0]) begin
        failures = failures + 1;
        $display("FAIL model t=%0t pc=%h/%h ir=%h/%h state=%b/%b rd=%b/%b act=%b/%b err=%b/%b",
                 $time, pc, m_pc, ir, m_ir, state, m_exec, instr_read,
                 (!m_exec && !m_halted), active, m_active, addr_error, m_err);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply inputs for the coming edge, then return just after it.
  task automatic cyc(input logic b, input logic [31:0] t, input logic h);
    branch = b; branch_target = t; halt = h;
    @(posedge clk); #2;
  endtask

  // One instruction: FETCH with junk on the don't-care inputs, then EXEC.
  task automatic instr(input logic b, input logic [31:0] t, input logic h);
    cyc(1'($urandom), $urandom, 1'($urandom));
    cyc(b, t, h);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'($urandom), $urandom, 1'($urandom));
    cyc(1'($urandom), $urandom, 1'($urandom));
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("reset_pc", pc, 32'hBFC0_0000);
    chk("reset_state", {31'h0, state}, 32'h0);
    chk("reset_rd", {31'h0, instr_read}, 32'h1);
    chk("reset_active", {31'h0, active}, 32'h1);
    chk("reset_err", {31'h0, addr_error}, 32'h0);
    cyc(1'b0, 32'h0, 1'b0);
    chk("fetch_state", {31'h0, state}, 32'h1);
    chk("fetch_ir", ir, 32'h0167_0F80);

    // Straight-line
    cyc(1'b0, 32'h0, 1'b0);
    chk("seq_addr1", instr_addr, 32'hBFC0_0004);
    chk("seq_state1", {31'h0, state}, 32'h0);
    instr(1'b0, 32'h0, 1'b0);
    chk("seq_addr2", instr_addr, 32'hBFC0_0008);

    // JR with delay slot at 0010
    instr(1'b0, 32'h0, 1'b0);
    instr(1'b0, 32'h0, 1'b0);
    chk("pc_0010", pc, 32'hBFC0_0010);
    instr(1'b1, 32'hBFC0_0100, 1'b0);
    chk("jr_slot", instr_addr, 32'hBFC0_0014);
    instr(1'b0, 32'h0, 1'b0);
    chk("jr_target", instr_addr, 32'hBFC0_0100);

    // JR in the delay slot
    do_reset();
    repeat (4) instr(1'b0, 32'h0, 1'b0);
    instr(1'b1, 32'hBFC0_0100, 1'b0);
    chk("chain_0014", instr_addr, 32'hBFC0_0014);
    instr(1'b1, 32'hBFC0_0200, 1'b0);
    chk("chain_0100", instr_addr, 32'hBFC0_0100);
    instr(1'b0, 32'h0, 1'b0);
    chk("chain_0200", instr_addr, 32'hBFC0_0200);

    // Halt beats branch
    do_reset();
    repeat (2) instr(1'b0, 32'h0, 1'b0);
    instr(1'b1, 32'hBFC0_0100, 1'b1);
    chk("halt_active", {31'h0, active}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom), $urandom, 1'($urandom));
      chk("halt_pc", pc, 32'hBFC0_0008);
      chk("halt_rd", {31'h0, instr_read}, 32'h0);
    end

    // Misaligned target with a branch still pending, then reset
    do_reset();
    instr(1'b1, 32'hBFC0_0100, 1'b0);
    instr(1'b1, 32'hBFC0_0102, 1'b0);
    chk("fault_err", {31'h0, addr_error}, 32'h1);
    chk("fault_active", {31'h0, active}, 32'h0);
    repeat (3) cyc(1'($urandom), $urandom, 1'($urandom));
    do_reset();
    chk("rst_err", {31'h0, addr_error}, 32'h0);
    instr(1'b0, 32'h0, 1'b0);
    chk("no_stale_pending", instr_addr, 32'hBFC0_0004);

    // PC wrap
    instr(1'b1, 32'hFFFF_FFFC, 1'b0);
    instr(1'b0, 32'h0, 1'b0);
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    instr(1'b0, 32'h0, 1'b0);
    chk("wrap_zero", pc, 32'h0000_0000);

    // Random run; reset a few cycles after each halt
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if (m_halted && m_halt_cycles > 3) begin
        do_reset();
      end else begin
        logic        b, h;
        logic [31:0] t;
        b = ($urandom_range(0, 3) == 0);
        h = ($urandom_range(0, 59) == 0);
        t = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 39) == 0) t[1:0] = 2'($urandom_range(1, 3));
        cyc(b, t, h);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Upstream neighbour of the control decoder in the Harvard 5-instruction core. Owns the PC, instruction register (IR) and the fetch/execute phase FSM. Drives the 1-bit `state`, `instruction_opcode` and `func_code` the decoder consumes. Consumes the decoder's Branch/halt outputs plus the JR target to sequence the PC, including one MIPS branch-delay slot.

Parameters:
RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
ADDR_W, 32, PC / instruction address width.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
instr_addr  out  ADDR_W  instruction ROM address; equals pc.
instr_read  out  1  high in FETCH only.
instr_rdata  in  32  instruction word; asynchronous ROM read, valid same cycle as instr_addr.
state  out  1  0 = FETCH (or HALTED), 1 = EXEC; to decoder.
instruction_opcode  out  6  ir[31:26].
func_code  out  6  ir[5:0].
ir  out  32  full instruction register, for regfile/immediate paths.
pc  out  ADDR_W  address of the instruction in ir.
branch  in  1  decoder Branch; sampled in EXEC only.
branch_target  in  ADDR_W  rs register value for JR; sampled with branch.
halt  in  1  decoder halt; sampled in EXEC only.
active  out  1  high until halted or faulted.
addr_error  out  1  sticky; misaligned branch target taken.

Behaviour:
- Reset (synchronous, any state, overrides everything):
  - pc=RESET_VECTOR, ir=0, fsm=FETCH, pending=0, pending_target=0, active=1, addr_error=0.
  - Any in-flight delay-slot branch is discarded.
- FSM states: FETCH, EXEC, HALTED.
  - state = (fsm==EXEC).
  - instr_read = (fsm==FETCH).
  - instr_addr = pc in every state.
- FETCH, one cycle:
  - ir <= instr_rdata; next = EXEC. pc unchanged.
  - opcode/func_code still reflect the previous ir (decoder ignores them while state=0).
- EXEC, one cycle. Decoder outputs are valid combinationally from ir. At the clock edge, in priority order:
  1. halt=1: next = HALTED, active <= 0. pc, ir and pending hold. Branch is ignored.
  2. branch=1 with branch_target[1:0] != 0: addr_error <= 1, active <= 0, next = HALTED.
  3. Otherwise:
     - pc <= pending ? pending_target : pc+4.
     - Then, if branch=1: pending <= 1, pending_target <= branch_target. Else pending <= 0.
     - next = FETCH.
- Delay slot: the instruction after a JR always executes, then the PC jumps.
  - Instruction latency: 2 cycles per instruction (FETCH + EXEC).
  - Taken-branch effect is visible on instr_addr at the FETCH following the delay-slot EXEC.
- Branch in the delay slot: the old pending target is applied to pc, and the new target becomes pending. The branch chain is honoured in order.
- Arithmetic: pc+4 is modulo 2^ADDR_W. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- HALTED: absorbing until reset.
  - state=0, instr_read=0, active=0.
  - pc and ir hold; branch and halt are ignored.
- Inputs branch, halt and branch_target are don't-care outside EXEC and must not affect state. X on them in FETCH must not propagate.

Decomposition:
- Shared package cpu_pkg:
  - OP_RTYPE=6'h00, OP_HALT=6'h3F, FUNC_JR=6'h08.
  - Enum fetch_state_t {FETCH, EXEC, HALTED}.
  - Default RESET_VECTOR.
- No sub-module needed. The pc/pending_target pair stays in this module's single always_ff block, with next-state logic in always_comb.

Test Plan:
- Reset: assert reset 2 cycles, release.
  - -> pc=32'hBFC0_0000, state=0, instr_read=1, active=1, addr_error=0.
  - Next edge state=1 and ir=instr_rdata.
- Straight-line: feed three ADDU words.
  - -> instr_addr sequence BFC0_0000, BFC0_0004, BFC0_0008.
  - state toggles 0,1,0,1.
- JR with delay slot: at pc=BFC0_0010 drive branch=1, target=BFC0_0100 in EXEC.
  - -> next fetch BFC0_0014 (delay slot), then BFC0_0100.
- JR in delay slot: branch to BFC0_0100, then branch to BFC0_0200 in the slot.
  - -> fetches 0014, 0100, 0200.
- Halt: halt=1 in EXEC at pc=BFC0_0008 with branch=1.
  - -> HALTED, active=0, pc stays BFC0_0008, instr_read=0 for 10 cycles.
- Fault/reset: branch target BFC0_0102.
  - -> addr_error=1, active=0.
  - Then reset mid-HALTED -> all reset values restored; a pending target from before reset is not applied.
